ssd_display_arbiter: RTL and testbench
======================================

Name: ssd_display_arbiter

Overview:
Shares the 8-digit seven-segment display between up to NUM_REQ independent requesters, such as the UART RX/TX debug paths.
- Grants requesters round-robin.
- Latches the granted 32-bit value and decimal-point mask.
- Holds each value on display for a guaranteed minimum time.
- Blanks the display after a configurable idle timeout.
- Its display_val, dp and blank outputs connect directly to the corresponding inputs of seven_segment.

Parameters:
CLK_FREQUENCY, 100_000_000, input clock frequency in Hz
NUM_REQ, 4, number of requesters (2..8)
HOLD_US, 1000, minimum display time per grant in microseconds (must be ≥1); HOLD_CYCLES = CLK_FREQUENCY/1_000_000*HOLD_US
BLANK_TIMEOUT_US, 1_000_000, idle time before blanking in microseconds; 0 disables blanking; BLANK_CYCLES derived the same way as HOLD_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i wants display
req_value  in  32*NUM_REQ  requester i value at [32i+31:32i]
req_dp  in  8*NUM_REQ  requester i dp mask at [8i+7:8i]
req_ack  out  NUM_REQ  one-hot, one-cycle grant pulse
display_val  out  32  value to seven_segment
dp  out  8  dp mask to seven_segment
blank  out  1  blank to seven_segment
active_id  out  $clog2(NUM_REQ)  index of last granted requester
busy  out  1  high while minimum hold time is running

Behaviour:
- Reset (rst=0, async):
  - Outputs: display_val=0, dp=0, blank=1, req_ack=0, active_id=0, busy=0.
  - FSM state=BLANKED; last-grant pointer=NUM_REQ-1, so requester 0 is searched first.
- All outputs are registered. A mid-operation reset aborts the hold immediately, and any pending requests are re-arbitrated after release.
- FSM states: BLANKED, HOLD, IDLE.
- Arbitration:
  - Search req_valid starting at (pointer+1) mod NUM_REQ, wrapping; the first set bit is granted.
  - The pointer updates to the granted index.
- Grant at a clock edge (1-edge latency: req_valid sampled high at edge k, outputs updated after edge k). At that edge:
  - display_val/dp ← the granted requester's slice.
  - req_ack[g]=1 for exactly that one cycle.
  - active_id=g, blank=0, busy=1.
  - hold counter ← HOLD_CYCLES-1; state → HOLD.
- Requester handshake:
  - Hold valid, value and dp stable until ack.
  - Valid still high in the cycle after ack counts as a new request.
  - Valid dropped before being sampled means no grant.
- BLANKED or IDLE: if any req_valid, grant. Otherwise:
  - BLANKED: outputs unchanged.
  - IDLE: decrement the idle counter. When it is 0 and BLANK_TIMEOUT_US≠0 → BLANKED, blank=1; display_val/dp retain their values.
- HOLD:
  - Counter≠0: decrement; ignore requests but do not lose them (requesters keep valid asserted).
  - Counter=0 and any valid: grant directly, back-to-back. Consecutive grants are therefore exactly HOLD_CYCLES cycles apart.
  - Counter=0 and no valid: busy=0, idle counter ← BLANK_CYCLES-1, state → IDLE.
- Simultaneous request and idle timeout: the grant wins, blank stays 0.
- HOLD_CYCLES=1: a grant is possible every cycle.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(BLANK_CYCLES+1). No wrap-around; counters saturate at 0.
- While state≠HOLD, busy=0.

Test Plan:
Test parameters for every scenario: CLK_FREQUENCY=100_000_000, HOLD_US=1 (100 cycles), BLANK_TIMEOUT_US=5 (500 cycles), NUM_REQ=4.
1. Reset: rst=0 for 5 cycles with all req_valid high.
   → blank=1, display_val=0, dp=0, req_ack=0, busy=0 throughout. Also assert rst asynchronously mid-cycle → outputs clear before the next edge.
2. Single request: req_valid[2], value 32'hdeadbeef, dp 8'hf0.
   → req_ack=4'b0100 for one cycle; display_val=deadbeef, dp=f0, active_id=2, blank=0.
   → busy=1 for exactly 100 cycles; req_ack never re-pulses while valid is held low.
3. Round-robin: all four valid continuously with values fedcba98, 76543210, a5a5a5a5, 5a5a5a5a.
   → grants 0,1,2,3,0 with acks exactly 100 cycles apart; display_val matches each granted value.
4. Hold respected: grant requester 3, then raise req_valid[1] 10 cycles later.
   → no ack until 100 cycles after requester 3's ack; then req_ack[1], display_val updated.
5. Idle blanking: one grant, then no requests.
   → value held for 100+500 cycles, then blank=1 with display_val unchanged.
   → repeat with req_valid[0] rising on the timeout cycle → grant, blank remains 0.
6. Reset mid-hold, then random: reset during HOLD of requester 2 → reset values; after release, requester 0 wins the first contention. Then apply 6 random values/dp masks.
   → each is acked in order, and seven_segment_check output_display_val matches each value.

Source files
------------

// File: rtl/ssd_display_arbiter.sv
// Round-robin arbiter sharing the 8-digit seven-segment display between NUM_REQ requesters.
// Each grant is held for at least HOLD_CYCLES; the display blanks after an idle timeout.
`timescale 1ns/1ps
module ssd_display_arbiter #(
  parameter int CLK_FREQUENCY    = 100_000_000,
  parameter int NUM_REQ          = 4,
  parameter int HOLD_US          = 1000,
  parameter int BLANK_TIMEOUT_US = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [32*NUM_REQ-1:0]      req_value,
  input  logic [8*NUM_REQ-1:0]       req_dp,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [31:0]                display_val,
  output logic [7:0]                 dp,
  output logic                       blank,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy
);

  localparam int IW           = $clog2(NUM_REQ);
  localparam int HOLD_CYCLES  = CLK_FREQUENCY / 1_000_000 * HOLD_US;
  localparam int BLANK_CYCLES = CLK_FREQUENCY / 1_000_000 * BLANK_TIMEOUT_US;
  localparam int HW           = $clog2(HOLD_CYCLES + 1);
  // Keep the idle counter at least one bit wide even when blanking is disabled.
  localparam int BW           = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam bit BLANK_EN     = (BLANK_CYCLES > 0);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {BLANKED, HOLD, IDLE} state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       ptr_reg, ptr_next;
  logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;
  logic [BW-1:0]       idle_cnt_reg, idle_cnt_next;
  logic [31:0]         val_reg, val_next;
  logic [7:0]          dp_reg, dp_next;
  logic                blank_reg, blank_next;
  logic [NUM_REQ-1:0]  ack_reg, ack_next;
  logic [IW-1:0]       id_reg, id_next;
  logic                busy_reg, busy_next;

  logic [31:0]         slot_val [NUM_REQ];
  logic [7:0]          slot_dp  [NUM_REQ];
  logic                grant_hit;
  logic [IW-1:0]       grant_idx;
  logic [IW:0]         cand_sum;
  logic [IW-1:0]       cand_idx;
  logic                do_grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign slot_val[gi] = req_value[32*gi +: 32];
    assign slot_dp[gi]  = req_dp[8*gi +: 8];
  end

  // Scan from the farthest candidate back to ptr+1 so the nearest valid requester wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_sum = {1'b0, ptr_reg} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(NUM_REQ))
        cand_sum = cand_sum - (IW+1)'(NUM_REQ);
      cand_idx = cand_sum[IW-1:0];
      if (req_valid[cand_idx]) begin
        grant_hit = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    val_next      = val_reg;
    dp_next       = dp_reg;
    blank_next    = blank_reg;
    ack_next      = '0;
    id_next       = id_reg;
    busy_next     = busy_reg;
    do_grant      = 1'b0;

    case (state_reg)
      BLANKED: do_grant = grant_hit;
      IDLE: begin
        if (grant_hit)
          do_grant = 1'b1;
        else if (idle_cnt_reg != '0)
          idle_cnt_next = idle_cnt_reg - BW'(1);
        else if (BLANK_EN) begin
          state_next = BLANKED;
          blank_next = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_reg != '0)
          hold_cnt_next = hold_cnt_reg - HW'(1);
        else if (grant_hit)
          do_grant = 1'b1;
        else begin
          busy_next     = 1'b0;
          idle_cnt_next = BLANK_LOAD;
          state_next    = IDLE;
        end
      end
      default: state_next = BLANKED;
    endcase

    // A grant overrides any idle-timeout decision taken in the same cycle.
    if (do_grant) begin
      val_next      = slot_val[grant_idx];
      dp_next       = slot_dp[grant_idx];
      ack_next      = NUM_REQ'(1) << grant_idx;
      id_next       = grant_idx;
      ptr_next      = grant_idx;
      blank_next    = 1'b0;
      busy_next     = 1'b1;
      hold_cnt_next = HOLD_LOAD;
      state_next    = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= BLANKED;
      ptr_reg      <= IW'(NUM_REQ - 1);
      hold_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      val_reg      <= '0;
      dp_reg       <= '0;
      blank_reg    <= 1'b1;
      ack_reg      <= '0;
      id_reg       <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      val_reg      <= val_next;
      dp_reg       <= dp_next;
      blank_reg    <= blank_next;
      ack_reg      <= ack_next;
      id_reg       <= id_next;
      busy_reg     <= busy_next;
    end
  end

  assign req_ack     = ack_reg;
  assign display_val = val_reg;
  assign dp          = dp_reg;
  assign blank       = blank_reg;
  assign active_id   = id_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Bench for ssd_display_arbiter: scoreboard of expected grants, contention vector table,
// and hand-written sequences for hold spacing, idle blanking and mid-hold reset.
`timescale 1ns/1ps
module tb_ssd_display_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_value = '0;
  logic [31:0]  req_dp = '0;
  logic [3:0]   req_ack;
  logic [31:0]  display_val;
  logic [7:0]   dp;
  logic         blank;
  logic [1:0]   active_id;
  logic         busy;

  always #5 clk = ~clk;

  ssd_display_arbiter #(
    .CLK_FREQUENCY(100_000_000), .NUM_REQ(4), .HOLD_US(1), .BLANK_TIMEOUT_US(5)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value), .req_dp(req_dp),
    .req_ack(req_ack), .display_val(display_val), .dp(dp), .blank(blank),
    .active_id(active_id), .busy(busy)
  );

  typedef struct {int id; logic [31:0] val; logic [7:0] dpm;} exp_t;
  typedef struct {logic [3:0] mask; int exp_id;} cvec_t;
  typedef struct {int who; logic [31:0] val; logic [7:0] dpm;} rvec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ack_count = 0;
  exp_t sb[$];
  int   ack_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] v, input logic [7:0] d);
    req_value[32*i +: 32] = v;
    req_dp[8*i +: 8]      = d;
  endtask

  task automatic push_exp(input int i, input logic [31:0] v, input logic [7:0] d);
    exp_t e;
    e.id = i; e.val = v; e.dpm = d;
    sb.push_back(e);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int t = 0;
    while (ack_count < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (ack_count < target) begin
      bad++;
      $display("FAIL %s: timeout got %0d acks want %0d", name, ack_count, target);
    end
  endtask

  task automatic wait_not_busy(input int budget, input string name);
    int t = 0;
    while (busy === 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blank"}, 32'(blank), 1);
    chk({tag, "_display_val"}, display_val, 0);
    chk({tag, "_dp"}, 32'(dp), 0);
    chk({tag, "_req_ack"}, 32'(req_ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_active_id"}, 32'(active_id), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    rst = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Output monitor: sampled 1 ns after each active edge, one line per grant.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (req_ack != '0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=%b want none (cycle %0d)", req_ack, cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_onehot", 32'(req_ack), 32'(1) << e.id);
          chk("display_val", display_val, e.val);
          chk("dp", 32'(dp), 32'(e.dpm));
          chk("active_id", 32'(active_id), e.id);
          chk("blank_on_grant", 32'(blank), 0);
          chk("busy_on_grant", 32'(busy), 1);
        end
        ack_count++;
        ack_cyc.push_back(cyc);
        $display("ack %0d at cycle %0d: req_ack=%b val=%h dp=%h", ack_count, cyc, req_ack, display_val, dp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] vals [4];
    logic [7:0]  dps  [4];
    cvec_t       cv [6];
    rvec_t       rv [6];
    int          n, base, a1, a2, a3;

    vals[0] = 32'hfedcba98; vals[1] = 32'h76543210; vals[2] = 32'ha5a5a5a5; vals[3] = 32'h5a5a5a5a;
    dps[0] = 8'h01; dps[1] = 8'h22; dps[2] = 8'h44; dps[3] = 8'h88;
    // Expected winners assume the pointer starts at 3 after reset and follows each grant.
    cv[0] = '{4'b1010, 1};
    cv[1] = '{4'b0011, 0};
    cv[2] = '{4'b1001, 3};
    cv[3] = '{4'b1000, 3};
    cv[4] = '{4'b0110, 1};
    cv[5] = '{4'b1111, 2};
    for (int i = 0; i < 6; i++) begin
      rv[i].who = int'($urandom_range(0, 3));
      rv[i].val = $urandom;
      rv[i].dpm = 8'($urandom);
    end

    // 1: reset held with every requester asserting
    rst = 1'b0;
    req_valid = 4'hf;
    for (int i = 0; i < 4; i++) set_req(i, vals[i], dps[i]);
    repeat (5) begin
      @(negedge clk);
      check_reset_outputs("t1_reset");
    end
    req_valid = '0;
    rst = 1'b1;

    // 2: single request on requester 2
    set_req(2, 32'hdeadbeef, 8'hf0);
    req_valid[2] = 1'b1;
    push_exp(2, 32'hdeadbeef, 8'hf0);
    wait_acks(ack_count + 1, 20, "t2_ack");
    req_valid[2] = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("t2_busy_cycles", n, 100);
    repeat (50) @(negedge clk);

    // contention table from a fresh pointer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) set_req(j, vals[j], dps[j]);
      req_valid = cv[i].mask;
      push_exp(cv[i].exp_id, vals[cv[i].exp_id], dps[cv[i].exp_id]);
      wait_acks(ack_count + 1, 20, "tc_ack");
      req_valid = '0;
      wait_not_busy(150, "tc_busy_release");
    end

    // 3: round robin with all four requesters continuously valid
    do_reset();
    for (int j = 0; j < 4; j++) set_req(j, vals[j], dps[j]);
    base = ack_cyc.size();
    n = ack_count + 5;
    push_exp(0, vals[0], dps[0]);
    push_exp(1, vals[1], dps[1]);
    push_exp(2, vals[2], dps[2]);
    push_exp(3, vals[3], dps[3]);
    push_exp(0, vals[0], dps[0]);
    req_valid = 4'hf;
    wait_acks(n, 600, "t3_acks");
    req_valid = '0;
    if (ack_cyc.size() >= base + 5)
      for (int k = 1; k < 5; k++)
        chk("t3_interval", ack_cyc[base+k] - ack_cyc[base+k-1], 100);

    // 4: a request raised mid-hold waits for the hold to expire
    wait_not_busy(200, "t4_idle_first");
    set_req(3, 32'h33330003, 8'h3c);
    req_valid[3] = 1'b1;
    push_exp(3, 32'h33330003, 8'h3c);
    wait_acks(ack_count + 1, 20, "t4_ack3");
    req_valid[3] = 1'b0;
    a3 = ack_cyc[$];
    repeat (10) @(negedge clk);
    set_req(1, 32'h11110001, 8'h1e);
    req_valid[1] = 1'b1;
    push_exp(1, 32'h11110001, 8'h1e);
    wait_acks(ack_count + 1, 200, "t4_ack1");
    req_valid[1] = 1'b0;
    chk("t4_interval", ack_cyc[$] - a3, 100);

    // 5: idle blanking after hold + timeout, value retained
    a1 = ack_cyc[$];
    while (blank !== 1'b1 && cyc < a1 + 800) @(negedge clk);
    chk("t5_blank_cycle", cyc - a1, 600);
    chk("t5_val_retained", display_val, 32'h11110001);
    chk("t5_dp_retained", 32'(dp), 32'h1e);
    chk("t5_busy_idle", 32'(busy), 0);

    // 5b: request arriving on the timeout edge wins over blanking
    set_req(2, 32'h22220002, 8'h2d);
    req_valid[2] = 1'b1;
    push_exp(2, 32'h22220002, 8'h2d);
    wait_acks(ack_count + 1, 20, "t5b_ack2");
    req_valid[2] = 1'b0;
    a2 = ack_cyc[$];
    while (cyc < a2 + 599) @(negedge clk);
    chk("t5b_blank_before_timeout", 32'(blank), 0);
    set_req(0, 32'h00000abc, 8'h0f);
    req_valid[0] = 1'b1;
    push_exp(0, 32'h00000abc, 8'h0f);
    wait_acks(ack_count + 1, 10, "t5b_ack0");
    req_valid[0] = 1'b0;
    chk("t5b_grant_at_timeout", ack_cyc[$] - a2, 600);
    repeat (3) @(negedge clk);
    chk("t5b_blank_stays_low", 32'(blank), 0);

    // 6: asynchronous reset in the middle of requester 2's hold
    set_req(2, 32'hcafe0002, 8'h5a);
    req_valid[2] = 1'b1;
    push_exp(2, 32'hcafe0002, 8'h5a);
    wait_acks(ack_count + 1, 250, "t6_ack2");
    req_valid[2] = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_busy_before_reset", 32'(busy), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    set_req(0, vals[0], dps[0]);
    set_req(2, vals[2], dps[2]);
    req_valid = 4'b0101;
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_in_reset");
    push_exp(0, vals[0], dps[0]);
    push_exp(2, vals[2], dps[2]);
    rst = 1'b1;
    wait_acks(ack_count + 1, 20, "t6_first_after_reset");
    req_valid[0] = 1'b0;
    wait_acks(ack_count + 1, 250, "t6_second_after_reset");
    req_valid[2] = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_req(rv[i].who, rv[i].val, rv[i].dpm);
      req_valid[rv[i].who] = 1'b1;
      push_exp(rv[i].who, rv[i].val, rv[i].dpm);
      wait_acks(ack_count + 1, 250, "t6_random_ack");
      req_valid[rv[i].who] = 1'b0;
    end
    repeat (20) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
